fcbt_group_arbiter: RTL and testbench



---
 rtl/fcbt_arb_pkg.sv | 23 ++
 rtl/fcbt_tag_fifo.sv | 57 +++++
 rtl/fcbt_group_arbiter.sv | 151 +++++++++++++++
 tb/tb_fcbt_group_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcbt_arb_pkg.sv
// Shared types and sizing helpers for the fcbt group arbiter.
package fcbt_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_MAX_OUTSTANDING = 8;

    function automatic int req_id_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

    function automatic int outstanding_bits(input int m);
        return $clog2(m) + 1;
    endfunction

    localparam int OUTSTANDING_W = outstanding_bits(DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/fcbt_tag_fifo.sv
// In-order owner tag FIFO; push and pop may occur in the same cycle.
module fcbt_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fcbt_group_arbiter.sv
// Round-robin group arbiter in front of a shared fcbt accumulator,
// steering each result back to the requester that issued the group.
module fcbt_group_arbiter
    import fcbt_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           acc_in,
    output logic                       acc_valid_in,
    output logic                       acc_end_of_group,
    input  logic                       acc_ready,
    input  logic [WIDTH-1:0]           acc_out,
    input  logic                       acc_valid_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy,
    output logic [outstanding_bits(MAX_OUTSTANDING)-1:0] outstanding,
    output logic                       err_underflow
);

    localparam int IDW = req_id_bits(NUM_REQ);
    localparam int CW  = outstanding_bits(MAX_OUTSTANDING);

    arb_state_t       state;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick;
    logic             pick_ok;
    int               idx;
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    logic             in_burst;
    logic             g_valid;
    logic             g_last;
    logic             xfer;
    logic             push;
    logic             pop;

    logic [IDW-1:0]   fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_ok && req_valid[idx]) begin
                pick    = IDW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    assign in_burst = (state == BURST);
    assign g_valid  = req_valid[grant];
    assign g_last   = req_last[grant];
    assign xfer     = in_burst & g_valid & acc_ready;
    assign push     = xfer & g_last;
    assign pop      = acc_valid_out & ~fifo_empty;

    always_comb begin
        acc_in           = '0;
        acc_valid_in     = 1'b0;
        acc_end_of_group = 1'b0;
        req_ready        = '0;
        if (in_burst) begin
            acc_in           = data_arr[grant];
            acc_valid_in     = g_valid & acc_ready;
            acc_end_of_group = g_last & g_valid & acc_ready;
            req_ready[grant] = acc_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_ok && !fifo_full) begin
                        grant <= pick;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (push) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ?
                                  '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result steering: one cycle after acc_valid_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[fifo_head] <= 1'b1;
                rsp_data             <= acc_out;
            end
            if (acc_valid_out && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    fcbt_tag_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (grant),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign busy        = in_burst | ~fifo_empty;
    assign outstanding = fifo_count;

endmodule

// File: tb/tb_fcbt_group_arbiter.sv
// Scoreboard bench for fcbt_group_arbiter: queued expectations for
// accumulator beats and steered results, checked by negedge monitors.
module tb_fcbt_group_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int M = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   acc_in;
    logic           acc_valid_in;
    logic           acc_end_of_group;
    logic           acc_ready;
    logic [W-1:0]   acc_out;
    logic           acc_valid_out;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic [3:0]     outstanding;
    logic           err_underflow;

    fcbt_group_arbiter #(
        .NUM_REQ         (N),
        .WIDTH           (W),
        .MAX_OUTSTANDING (M)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .acc_in           (acc_in),
        .acc_valid_in     (acc_valid_in),
        .acc_end_of_group (acc_end_of_group),
        .acc_ready        (acc_ready),
        .acc_out          (acc_out),
        .acc_valid_out    (acc_valid_out),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .busy             (busy),
        .outstanding      (outstanding),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    logic [W:0]   rq [N][$];
    logic [N-1:0] en;
    logic [N-1:0] fire_q;
    logic [W:0]   exp_acc [$];
    logic [N+W-1:0] exp_rsp [$];
    int           beat_cyc [$];
    bit           rec = 1'b0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W:0]   ma_e;
    logic [N+W-1:0] mr_e;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) fire_q = req_valid & req_ready;

    // Requester models: present queue heads, retire on accepted beats.
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (fire_q[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0 && en[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*W +: W]  = rq[i][0][W-1:0];
                req_last[i]         = rq[i][0][W];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        fire_q = '0;
    end

    always @(negedge clk) begin
        if (!rst && acc_valid_in) begin
            if (rec) beat_cyc.push_back(cyc);
            if (exp_acc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL acc_extra: got %0h expected none", acc_in);
            end else begin
                ma_e = exp_acc.pop_front();
                check("acc_beat", {acc_end_of_group, acc_in}, ma_e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_extra: got %0h/%0h expected none",
                         rsp_valid, rsp_data);
            end else begin
                mr_e = exp_rsp.pop_front();
                check("rsp", {rsp_valid, rsp_data}, mr_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(int r, logic [W-1:0] d, bit last, bit expect_acc);
        rq[r].push_back({last, d});
        if (expect_acc) exp_acc.push_back({last, d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic inject(int owner, logic [W-1:0] d);
        logic [N-1:0] oh;
        oh        = '0;
        oh[owner] = 1'b1;
        acc_valid_out = 1'b1;
        acc_out       = d;
        exp_rsp.push_back({oh, d});
        tick();
        acc_valid_out = 1'b0;
        @(negedge clk);
        #1;
        check("rsp_latency", exp_rsp.size(), 0);
    endtask

    task automatic wait_out(int v, string nm);
        int n;
        n = 0;
        while (outstanding !== 4'(v) && n < 200) begin
            tick();
            n++;
        end
        check(nm, outstanding, v);
    endtask

    task automatic wait_grant(int r, string nm);
        int n;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(nm, req_ready[r], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        acc_ready = 1'b0;
        acc_out = '0;
        acc_valid_out = 1'b0;
        en = '1;
        fire_q = '0;
        do_reset();
        @(negedge clk);
        check("rst_out", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_err", err_underflow, 0);
        check("rst_ready", req_ready, 0);
        check("rst_accv", acc_valid_in, 0);
        tick();

        // Single requester, two groups.
        acc_ready = 1'b1;
        enq(1, 1, 0, 1);
        enq(1, 2, 0, 1);
        enq(1, 3, 1, 1);
        enq(1, 10, 1, 1);
        wait_out(2, "t1_out");
        check("t1_beats", exp_acc.size(), 0);
        inject(1, 6);
        inject(1, 10);
        check("t1_drain", outstanding, 0);

        // Round-robin over four always-valid requesters.
        do_reset();
        beat_cyc.delete();
        rec = 1'b1;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N; i++) begin
                enq(i, 32'(i*16 + j*4 + 1), 0, 1);
                enq(i, 32'(i*16 + j*4 + 2), 1, 1);
            end
        end
        wait_out(8, "t2_full");
        rec = 1'b0;
        check("t2_nbeats", beat_cyc.size(), 16);
        bad = 0;
        for (int k = 1; k < beat_cyc.size(); k++) begin
            if (beat_cyc[k] - beat_cyc[k-1] != ((k % 2 == 1) ? 1 : 2)) bad++;
        end
        check("t2_bubble", bad, 0);
        check("t2_beats", exp_acc.size(), 0);
        for (int k = 0; k < 8; k++) inject(k % N, 32'(100 + k));
        check("t2_drain", outstanding, 0);

        // Full tag FIFO blocks the ninth grant.
        do_reset();
        for (int k = 0; k < 9; k++) enq(2, 32'(32 + k), 1, k < 8);
        wait_out(8, "t3_full");
        repeat (3) tick();
        @(negedge clk);
        check("t3_hold", outstanding, 8);
        check("t3_noready", req_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_left", rq[2].size(), 1);
        exp_acc.push_back({1'b1, 32'(40)});
        inject(2, 32'h55);
        check("t3_pop", outstanding, 7);
        tick();
        check("t3_grant_next", req_ready[2], 1);
        wait_out(8, "t3_refill");
        check("t3_beats", exp_acc.size(), 0);
        for (int k = 0; k < 8; k++) inject(2, 32'(32'h60 + k));
        check("t3_drain", outstanding, 0);

        // Backpressure and requester stalls mid-group.
        do_reset();
        enq(3, 32'h31, 0, 1);
        enq(3, 32'h32, 0, 1);
        enq(3, 32'h33, 1, 1);
        wait_grant(3, "t4_grant");
        tick();
        acc_ready = 1'b0;
        @(negedge clk);
        check("t4_stall_ready", acc_valid_in, 0);
        check("t4_ready_low", req_ready, 0);
        tick();
        acc_ready = 1'b1;
        tick();
        en[3] = 1'b0;
        @(negedge clk);
        check("t4_stall_valid", acc_valid_in, 0);
        check("t4_hold", req_ready, 4'b1000);
        tick();
        @(negedge clk);
        check("t4_stall_valid2", acc_valid_in, 0);
        tick();
        en[3] = 1'b1;
        wait_out(1, "t4_out");
        check("t4_beats", exp_acc.size(), 0);
        inject(3, 32'h99);

        // Push and pop in the same cycle.
        do_reset();
        enq(0, 1, 1, 1);
        enq(0, 2, 1, 1);
        enq(0, 3, 1, 1);
        wait_out(3, "t5_three");
        enq(1, 32'h11, 0, 1);
        enq(1, 32'h12, 1, 1);
        wait_grant(1, "t5_grant");
        tick();
        acc_valid_out = 1'b1;
        acc_out = 32'h77;
        exp_rsp.push_back({4'b0001, 32'h77});
        tick();
        acc_valid_out = 1'b0;
        check("t5_simul", outstanding, 3);
        @(negedge clk);
        #1;
        check("t5_rsp", exp_rsp.size(), 0);
        check("t5_beats", exp_acc.size(), 0);
        inject(0, 32'h78);
        inject(0, 32'h79);
        inject(1, 32'h7a);
        check("t5_drain", outstanding, 0);

        // Underflow, then reset in the middle of a burst.
        acc_valid_out = 1'b1;
        acc_out = 32'hdead;
        tick();
        acc_valid_out = 1'b0;
        @(negedge clk);
        check("t6_err", err_underflow, 1);
        check("t6_norsp", rsp_valid, 0);
        repeat (3) tick();
        check("t6_sticky", err_underflow, 1);
        enq(2, 32'h21, 0, 1);
        enq(2, 32'h22, 0, 0);
        enq(2, 32'h23, 1, 0);
        wait_grant(2, "t6_grant");
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_out", outstanding, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_accv", acc_valid_in, 0);
        check("t6_rst_eog", acc_end_of_group, 0);
        check("t6_rst_accin", acc_in, 0);
        check("t6_rst_rsp", rsp_valid, 0);
        check("t6_rst_data", rsp_data, 0);
        check("t6_rst_err", err_underflow, 0);

        check("end_acc", exp_acc.size(), 0);
        check("end_rsp", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
